uart_wr_fifo: RTL and testbench

- Upstream counterpart of the UART read-side FIFO stage: collects bytes from the UART receiver (rx_data/rx_flag) into an in-block local FIFO.
- Pushes them into the SDRAM interface write FIFO as contiguous bursts of burst_len bytes.
- If the line goes idle with a partial burst buffered, it pads the burst with PAD_BYTE after a timeout so the data still reaches SDRAM.
- Sits between uart_rx and the SDRAM interface write FIFO.

---
 rtl/uart_wr_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_wr_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wr_fifo.sv
// uart_wr_fifo
// Collects bytes from uart_rx into a local FIFO and forwards them to the
// SDRAM interface write FIFO as contiguous bursts of burst_len bytes. If the
// line goes idle with a partial burst buffered, the burst is padded with
// PAD_BYTE after TIMEOUT_CYCLES idle clocks so the data still reaches SDRAM.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   rx_data[7:0]        received byte, valid with rx_flag
//   rx_flag             one-cycle byte-valid strobe from uart_rx
//   burst_len[9:0]      burst length in bytes, 0 disables bursting
//   sdram_wr_fifo_cnt   current occupancy of the SDRAM write FIFO
//   sdram_fifo_wr_en    SDRAM write FIFO write strobe
//   sdram_fifo_wr_data  data aligned with sdram_fifo_wr_en
//   burst_done          high with the last beat of each burst
//   overflow            one-cycle pulse when a byte is dropped (local FIFO full)
//   local_cnt           local FIFO occupancy, 0..2^LOCAL_AW

module uart_wr_fifo #(
    parameter int unsigned LOCAL_AW         = 10,
    parameter int unsigned SDRAM_FIFO_DEPTH = 1024,
    parameter logic [19:0] TIMEOUT_CYCLES   = 20'd520800,
    parameter logic [7:0]  PAD_BYTE         = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_flag,
    input  logic [9:0]        burst_len,
    input  logic [9:0]        sdram_wr_fifo_cnt,
    output logic              sdram_fifo_wr_en,
    output logic [7:0]        sdram_fifo_wr_data,
    output logic              burst_done,
    output logic              overflow,
    output logic [LOCAL_AW:0] local_cnt
);

    localparam int unsigned DEPTH  = 1 << LOCAL_AW;
    localparam int unsigned CNT_W  = LOCAL_AW + 1;
    localparam int unsigned BLEN_W = 10;
    localparam int unsigned SUM_W  = BLEN_W + 1;
    localparam int unsigned TO_W   = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [BLEN_W-1:0]   blen;
    logic [BLEN_W-1:0]   real_num;
    logic [BLEN_W-1:0]   beat;
    logic                gap_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic [7:0]          mem [DEPTH];
    logic [LOCAL_AW-1:0] wr_ptr;
    logic [LOCAL_AW-1:0] rd_ptr;

    logic full_c;
    logic wr_c;
    logic issue_c;
    logic rd_c;
    logic last_beat_c;
    logic has_data_c;
    logic enough_c;
    logic timeout_c;
    logic space_ok_c;
    logic start_c;

    // Control decode
    always_comb begin
        full_c      = (local_cnt == CNT_W'(DEPTH));
        wr_c        = rx_flag && !full_c;
        issue_c     = (state == BURST);
        rd_c        = issue_c && (beat < real_num);
        last_beat_c = (beat == (blen - BLEN_W'(1)));
        has_data_c  = (local_cnt != '0);
        enough_c    = (local_cnt >= CNT_W'(burst_len));
        timeout_c   = (to_cnt == TIMEOUT_CYCLES);
        // Widened add so a nearly full SDRAM FIFO cannot wrap past the limit
        space_ok_c  = ((SUM_W'(sdram_wr_fifo_cnt) + SUM_W'(burst_len))
                       <= SUM_W'(SDRAM_FIFO_DEPTH));
        start_c     = (burst_len != '0)
                      && (enough_c || (timeout_c && has_data_c))
                      && space_ok_c;
    end

    // Local FIFO storage (no reset on the array itself)
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Local FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            local_cnt <= '0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + LOCAL_AW'(1);
            end
            if (rd_c) begin
                rd_ptr <= rd_ptr + LOCAL_AW'(1);
            end
            case ({wr_c, rd_c})
                2'b10:   local_cnt <= local_cnt + CNT_W'(1);
                2'b01:   local_cnt <= local_cnt - CNT_W'(1);
                default: local_cnt <= local_cnt;
            endcase
        end
    end

    // Idle timeout: only runs while IDLE with data waiting and the line quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (rx_flag || !has_data_c || (state != IDLE)) begin
            to_cnt <= '0;
        end else if (!timeout_c) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Burst sequencer; burst_len is latched so mid-burst changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            blen     <= '0;
            real_num <= '0;
            beat     <= '0;
            gap_cnt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= BURST;
                        blen     <= burst_len;
                        real_num <= enough_c ? burst_len : BLEN_W'(local_cnt);
                        beat     <= '0;
                    end
                end
                BURST: begin
                    beat <= beat + BLEN_W'(1);
                    if (last_beat_c) begin
                        state   <= GAP;
                        gap_cnt <= 1'b0;
                    end
                end
                GAP: begin
                    // Two cycles so the SDRAM FIFO count reflects this burst
                    if (gap_cnt) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output stage: the registered FIFO read doubles as the write-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_fifo_wr_en   <= 1'b0;
            sdram_fifo_wr_data <= '0;
            burst_done         <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            sdram_fifo_wr_en <= issue_c;
            burst_done       <= issue_c && last_beat_c;
            overflow         <= rx_flag && full_c;
            if (issue_c) begin
                sdram_fifo_wr_data <= rd_c ? mem[rd_ptr] : PAD_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_uart_wr_fifo.sv
// Directed bench for uart_wr_fifo (timeout shortened to 40 cycles).
module tb_uart_wr_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [9:0]  burst_len;
    logic [9:0]  sdram_wr_fifo_cnt;
    logic        sdram_fifo_wr_en;
    logic [7:0]  sdram_fifo_wr_data;
    logic        burst_done;
    logic        overflow;
    logic [10:0] local_cnt;

    uart_wr_fifo #(
        .LOCAL_AW         (10),
        .SDRAM_FIFO_DEPTH (1024),
        .TIMEOUT_CYCLES   (20'd40),
        .PAD_BYTE         (8'h00)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_flag            (rx_flag),
        .burst_len          (burst_len),
        .sdram_wr_fifo_cnt  (sdram_wr_fifo_cnt),
        .sdram_fifo_wr_en   (sdram_fifo_wr_en),
        .sdram_fifo_wr_data (sdram_fifo_wr_data),
        .burst_done         (burst_done),
        .overflow           (overflow),
        .local_cnt          (local_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat recorder: captures every write strobe shortly after the edge
    int q_data[$];
    int q_done[$];
    int q_cyc[$];
    always @(posedge clk) begin
        #2;
        if (sdram_fifo_wr_en === 1'b1) begin
            q_data.push_back(int'(sdram_fifo_wr_data));
            q_done.push_back(int'(burst_done));
            q_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_done.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge clk);
        rx_flag = 1'b0;
    endtask

    // Bounded wait for n recorded beats; an expired budget shows as a failure
    task automatic wait_beats(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (q_data.size() >= n) break;
            @(negedge clk);
        end
        check(tag, q_data.size(), n);
    endtask

    function automatic int qd(input int i);
        return (i < q_data.size()) ? q_data[i] : -1;
    endfunction

    function automatic int qe(input int i);
        return (i < q_done.size()) ? q_done[i] : -1;
    endfunction

    function automatic int qc(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1000;
    endfunction

    int       k;
    int       bad;
    int       bad_done;
    int       bad_gap;
    int       ndone;
    int       s;
    logic [7:0] exp2 [8];

    initial begin
        rst_n             = 1'b0;
        rx_data           = 8'h00;
        rx_flag           = 1'b0;
        burst_len         = 10'd0;
        sdram_wr_fifo_cnt = 10'd0;
        idle(3);
        check("rst_wr_en",    sdram_fifo_wr_en, 0);
        check("rst_wr_data",  sdram_fifo_wr_data, 0);
        check("rst_done",     burst_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_local_cnt", local_cnt, 0);
        rst_n = 1'b1;

        // 1: full burst of 8 bytes
        clear_q();
        burst_len = 10'd8;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_beats(8, 40, "t1_beats");
        idle(6);
        check("t1_count", q_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_data%0d", i), qd(i), i + 1);
            check($sformatf("t1_done%0d", i), qe(i), (i == 7) ? 1 : 0);
        end
        check("t1_contig", qc(7) - qc(0), 7);
        check("t1_local_cnt", local_cnt, 0);

        // 2: partial burst flushed by timeout, padded
        clear_q();
        exp2 = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        idle(30);
        check("t2_no_early", q_data.size(), 0);
        check("t2_local_cnt_wait", local_cnt, 3);
        wait_beats(8, 60, "t2_beats");
        idle(6);
        check("t2_count", q_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_data%0d", i), qd(i), int'(exp2[i]));
            check($sformatf("t2_done%0d", i), qe(i), (i == 7) ? 1 : 0);
        end
        check("t2_local_cnt", local_cnt, 0);

        // 3: SDRAM space check and start latency
        clear_q();
        burst_len         = 10'd16;
        sdram_wr_fifo_cnt = 10'd1010;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        idle(60);
        check("t3_blocked", q_data.size(), 0);
        check("t3_local_cnt_hold", local_cnt, 16);
        @(negedge clk);
        sdram_wr_fifo_cnt = 10'd1008;
        k = cyc;
        wait_beats(16, 40, "t3_beats");
        idle(6);
        check("t3_latency", qc(0) - k, 2);
        check("t3_contig", qc(15) - qc(0), 15);
        bad = 0;
        for (int i = 0; i < 16; i++) if (qd(i) != 16 + i) bad++;
        check("t3_data_errs", bad, 0);
        check("t3_done_last", qe(15), 1);
        check("t3_done_mid", qe(14), 0);
        check("t3_local_cnt", local_cnt, 0);
        sdram_wr_fifo_cnt = 10'd0;

        // 4: fill local FIFO, overflow one byte, then drain in order
        clear_q();
        burst_len = 10'd0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            rx_flag = 1'b1;
            rx_data = 8'(i);
        end
        @(negedge clk);
        check("t4_full_cnt", local_cnt, 1024);
        check("t4_no_ovf_yet", overflow, 0);
        rx_data = 8'hEE;
        @(negedge clk);
        check("t4_ovf_pulse", overflow, 1);
        check("t4_cnt_stays", local_cnt, 1024);
        rx_flag = 1'b0;
        @(negedge clk);
        check("t4_ovf_clear", overflow, 0);
        idle(50);
        check("t4_no_wr", q_data.size(), 0);
        burst_len = 10'd8;
        wait_beats(1024, 2000, "t4_drain");
        idle(6);
        bad   = 0;
        ndone = 0;
        for (int i = 0; i < 1024; i++) begin
            if (qd(i) != (i % 256)) bad++;
            if (qe(i) == 1) ndone++;
        end
        check("t4_order_errs", bad, 0);
        check("t4_done_count", ndone, 128);
        check("t4_local_cnt", local_cnt, 0);

        // 5: continuous trickle, bursts of 4
        clear_q();
        burst_len = 10'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_flag = 1'b1;
            rx_data = 8'(8'h40 + i);
            @(negedge clk);
            rx_flag = 1'b0;
            @(negedge clk);
        end
        wait_beats(20, 40, "t5_beats");
        idle(10);
        check("t5_count", q_data.size(), 20);
        bad      = 0;
        bad_done = 0;
        bad_gap  = 0;
        for (int i = 0; i < 20; i++) begin
            if (qd(i) != 8'h40 + i) bad++;
            if (qe(i) != ((i % 4 == 3) ? 1 : 0)) bad_done++;
            if (i % 4 != 0 && (qc(i) - qc(i - 1)) != 1) bad_gap++;
            if (i % 4 == 0 && i > 0 && (qc(i) - qc(i - 1)) < 3) bad_gap++;
        end
        check("t5_order_errs", bad, 0);
        check("t5_done_errs", bad_done, 0);
        check("t5_spacing_errs", bad_gap, 0);
        check("t5_local_cnt", local_cnt, 0);

        // 6: reset in the middle of a burst
        clear_q();
        burst_len = 10'd8;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i));
        wait_beats(3, 40, "t6_beats3");
        rst_n = 1'b0;
        #1;
        check("t6_wr_en_drop", sdram_fifo_wr_en, 0);
        check("t6_local_cnt", local_cnt, 0);
        check("t6_done_low", burst_done, 0);
        idle(2);
        rst_n = 1'b1;
        s = q_data.size();
        check("t6_beats_before", s, 3);
        check("t6_data2", qd(2), 8'h62);
        idle(80);
        check("t6_no_more", q_data.size(), s);
        check("t6_local_cnt_after", local_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
